// File: rtl/bcd_pkg.sv
// Shared types and the per-digit add-3 correction for the sequential
// binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  typedef logic [3:0] bcd_digit_t;

  // A digit of 5 or more doubles past 9 on the next shift, so pre-correct it.
  function automatic bcd_digit_t add3(input bcd_digit_t digit);
    return (digit >= 4'd5) ? bcd_digit_t'(digit + 4'd3) : digit;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One BCD digit of the shift-and-add-3 chain: correct, then shift left by one,
// taking carry_i in at the bottom and passing the old bit 3 out as carry_o.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [3:0] digit_i,
  input  logic       carry_i,
  output logic [3:0] digit_o,
  output logic       carry_o
);

  bcd_digit_t adj;

  always_comb begin
    adj     = add3(digit_i);
    digit_o = {adj[2:0], carry_i};
    carry_o = adj[3];
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter, one magnitude bit per clock, with
// valid/ready on both sides, optional signed input, overflow and digit count.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 10,
  parameter bit SIGNED = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DIGITS*4-1:0]           out_bcd,
  output logic                          out_neg,
  output logic                          out_ovf,
  output logic [$clog2(DIGITS+1)-1:0]   out_ndigits
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int ND_W  = $clog2(DIGITS + 1);

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    mag_q, mag_d;
  logic [DIGITS*4-1:0] bcd_q, bcd_d;
  logic                neg_q, neg_d;
  logic                ovf_q, ovf_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                in_neg;
  logic [WIDTH-1:0]    in_mag;
  logic [DIGITS*4-1:0] bcd_shift;
  logic [DIGITS:0]     carry;

  // Digit chain: the magnitude MSB enters digit 0, the top carry is overflow.
  assign carry[0] = mag_q[WIDTH-1];

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit_adj u_adj (
      .digit_i (bcd_q[4*g +: 4]),
      .carry_i (carry[g]),
      .digit_o (bcd_shift[4*g +: 4]),
      .carry_o (carry[g+1])
    );
  end

  // The most negative input negates to 2^(WIDTH-1), which still fits unsigned.
  always_comb begin
    in_neg = SIGNED && in_data[WIDTH-1];
    in_mag = in_neg ? ({WIDTH{1'b0}} - in_data) : in_data;
  end

  // State register
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  // NOTE: a default assignment ahead of the case keeps combinational blocks
  // from inferring latches on paths that do not assign.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid)               state_d = SHIFT;
      SHIFT:   if (cnt_q == CNT_W'(1))     state_d = DONE;
      DONE:    if (out_ready)              state_d = IDLE;
      default:                             state_d = IDLE;
    endcase
  end

  // Output logic: handshake flags depend on state only.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    out_bcd   = bcd_q;
    out_neg   = neg_q;
    out_ovf   = ovf_q;
  end

  // Datapath next values
  always_comb begin
    mag_d = mag_q;
    bcd_d = bcd_q;
    neg_d = neg_q;
    ovf_d = ovf_q;
    cnt_d = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          mag_d = in_mag;
          neg_d = in_neg;
          bcd_d = '0;
          ovf_d = 1'b0;
          cnt_d = CNT_W'(WIDTH);
        end
      end
      SHIFT: begin
        bcd_d = bcd_shift;
        mag_d = {mag_q[WIDTH-2:0], 1'b0};
        ovf_d = ovf_q | carry[DIGITS];
        cnt_d = cnt_q - CNT_W'(1);
      end
      default: ;
    endcase
  end

  // NOTE: every datapath register is reset, so an aborted conversion leaves
  // nothing visible on the outputs and nothing behind for the next word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag_q <= '0;
      bcd_q <= '0;
      neg_q <= 1'b0;
      ovf_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      mag_q <= mag_d;
      bcd_q <= bcd_d;
      neg_q <= neg_d;
      ovf_q <= ovf_d;
      cnt_q <= cnt_d;
    end
  end

  // Significant-digit count from the registered result.
  always_comb begin
    out_ndigits = ND_W'(1);
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] != 4'd0) out_ndigits = ND_W'(i + 1);
    end
    if (ovf_q) out_ndigits = ND_W'(DIGITS);
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Three converters (16b/5 digits unsigned, 16b/4 digits unsigned, 16b/5 digits
// signed) fed the same words in lockstep and checked against a decimal model.
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] in_data;
  logic        out_ready;

  logic        in_ready_a, in_ready_b, in_ready_c;
  logic        out_valid_a, out_valid_b, out_valid_c;
  logic [19:0] out_bcd_a, out_bcd_c;
  logic [15:0] out_bcd_b;
  logic        out_neg_a, out_neg_b, out_neg_c;
  logic        out_ovf_a, out_ovf_b, out_ovf_c;
  logic [2:0]  out_nd_a, out_nd_b, out_nd_c;

  int checks   = 0;
  int failures = 0;
  int n_out    = 0;
  logic [15:0] cur_word = '0;
  bit          have_word = 1'b0;

  always #5 clk = ~clk;

  bin_to_bcd_seq #(.WIDTH(16), .DIGITS(5), .SIGNED(1'b0)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_data(in_data), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_bcd(out_bcd_a), .out_neg(out_neg_a), .out_ovf(out_ovf_a),
    .out_ndigits(out_nd_a));

  bin_to_bcd_seq #(.WIDTH(16), .DIGITS(4), .SIGNED(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_data(in_data), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_bcd(out_bcd_b), .out_neg(out_neg_b), .out_ovf(out_ovf_b),
    .out_ndigits(out_nd_b));

  bin_to_bcd_seq #(.WIDTH(16), .DIGITS(5), .SIGNED(1'b1)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_c),
    .in_data(in_data), .out_valid(out_valid_c), .out_ready(out_ready),
    .out_bcd(out_bcd_c), .out_neg(out_neg_c), .out_ovf(out_ovf_c),
    .out_ndigits(out_nd_c));

  typedef struct packed {
    logic [19:0] bcd;
    logic        neg;
    logic        ovf;
    logic [2:0]  nd;
  } exp_t;

  // Decimal reference: magnitude, modulo 10^digits, digit extraction by /10.
  function automatic exp_t model(input logic [15:0] v, input int digits, input bit sgn);
    exp_t   e;
    longint mag, lim, r, dig;
    e     = '0;
    e.neg = sgn && v[15];
    mag   = e.neg ? (longint'(65536) - longint'(v)) : longint'(v);
    lim   = 1;
    for (int i = 0; i < digits; i++) lim = lim * 10;
    e.ovf = (mag >= lim);
    r     = mag % lim;
    e.nd  = 3'd1;
    for (int i = 0; i < digits; i++) begin
      dig = r % 10;
      e.bcd[4*i +: 4] = 4'(dig);
      if (dig != 0) e.nd = 3'(i + 1);
      r = r / 10;
    end
    if (e.ovf) e.nd = 3'(digits);
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Compare process: outputs are sampled on the falling edge, away from updates.
  always @(negedge clk) begin
    exp_t ea, eb, ec;
    if (rst_n) begin
      if (in_valid && in_ready_a) begin
        cur_word  = in_data;
        have_word = 1'b1;
      end
      check("lockstep_valid", {30'd0, out_valid_b, out_valid_c}, {30'd0, out_valid_a, out_valid_a});
      check("lockstep_ready", {30'd0, in_ready_b, in_ready_c}, {30'd0, in_ready_a, in_ready_a});
      if (out_valid_a) begin
        check("result_expected", 32'(have_word), 32'd1);
        ea = model(cur_word, 5, 1'b0);
        eb = model(cur_word, 4, 1'b0);
        ec = model(cur_word, 5, 1'b1);
        check("a_bcd", 32'(out_bcd_a), 32'(ea.bcd));
        check("a_neg_ovf_nd", {27'd0, out_neg_a, out_ovf_a, out_nd_a}, {27'd0, ea.neg, ea.ovf, ea.nd});
        check("b_bcd", 32'(out_bcd_b), 32'(eb.bcd));
        check("b_neg_ovf_nd", {27'd0, out_neg_b, out_ovf_b, out_nd_b}, {27'd0, eb.neg, eb.ovf, eb.nd});
        check("c_bcd", 32'(out_bcd_c), 32'(ec.bcd));
        check("c_neg_ovf_nd", {27'd0, out_neg_c, out_ovf_c, out_nd_c}, {27'd0, ec.neg, ec.ovf, ec.nd});
        check("in_ready_while_done", 32'(in_ready_a), 32'd0);
        if (out_ready) begin
          n_out++;
          have_word = 1'b0;
        end
      end
    end
  end

  task automatic send(input logic [15:0] w);
    int t = 0;
    while (!in_ready_a && t < 200) begin
      @(posedge clk); #1; t++;
    end
    check("in_ready_wait", 32'(in_ready_a), 32'd1);
    in_data  = w;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int t = 0;
    while (!out_valid_a && t < 100) begin
      @(posedge clk); #1; t++;
    end
    check("out_valid_wait", 32'(out_valid_a), 32'd1);
  endtask

  task automatic drain(input bit rnd);
    int t  = 0;
    int n0 = n_out;
    while (n_out == n0 && t < 300) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1; t++;
    end
    out_ready = 1'b0;
    check("result_consumed", 32'(n_out != n0), 32'd1);
  endtask

  initial begin
    logic [15:0] corners [8];
    int          n;
    corners = '{16'd0, 16'd1, 16'd9999, 16'd10000, 16'd65535, 16'h8000, 16'h7FFF, 16'd99};

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    // Model pinned to hand-computed values.
    check("model_65535_d5", 32'(model(16'd65535, 5, 1'b0)), 32'({20'h65535, 1'b0, 1'b0, 3'd5}));
    check("model_12345_d4", 32'(model(16'd12345, 4, 1'b0)), 32'({20'h02345, 1'b0, 1'b1, 3'd4}));
    check("model_8000_s",   32'(model(16'h8000, 5, 1'b1)),  32'({20'h32768, 1'b1, 1'b0, 3'd5}));
    check("model_ffff_s",   32'(model(16'hFFFF, 5, 1'b1)),  32'({20'h00001, 1'b1, 1'b0, 3'd1}));

    repeat (3) @(posedge clk);
    #1;
    check("rst_valid",  {29'd0, out_valid_a, out_valid_b, out_valid_c}, 32'd0);
    check("rst_ready",  {29'd0, in_ready_a, in_ready_b, in_ready_c}, 32'd7);
    check("rst_bcd_a",  32'(out_bcd_a), 32'd0);
    check("rst_flags",  {26'd0, out_neg_a, out_neg_c, out_ovf_a, out_ovf_b, out_ovf_c, out_neg_b}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Latency: edges counted from the one that accepts the word.
    in_data = 16'd65535; in_valid = 1'b1; n = 0;
    do begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      n++;
    end while (!out_valid_a && n < 100);
    check("latency_edges", 32'(n), 32'd17);
    check("a_65535_bcd", 32'(out_bcd_a), 32'h65535);
    check("a_65535_nd",  32'(out_nd_a),  32'd5);
    check("a_65535_ovf", 32'(out_ovf_a), 32'd0);
    check("b_65535_ovf", 32'(out_ovf_b), 32'd1);
    check("c_ffff_bcd",  32'(out_bcd_c), 32'h00001);
    check("c_ffff_neg_nd", {28'd0, out_neg_c, out_nd_c}, {28'd0, 1'b1, 3'd1});
    drain(1'b0);

    send(16'd12345); wait_valid();
    check("b_12345_bcd", 32'(out_bcd_b), 32'h2345);
    check("b_12345_ovf_nd", {28'd0, out_ovf_b, out_nd_b}, {28'd0, 1'b1, 3'd4});
    drain(1'b0);
    send(16'd9999); wait_valid();
    check("b_9999_ovf_cleared", 32'(out_ovf_b), 32'd0);
    check("b_9999_bcd", 32'(out_bcd_b), 32'h9999);
    drain(1'b0);

    send(16'h8000); wait_valid();
    check("c_8000_bcd", 32'(out_bcd_c), 32'h32768);
    check("c_8000_neg", 32'(out_neg_c), 32'd1);
    drain(1'b0);
    send(16'd0); wait_valid();
    check("c_zero", {12'd0, out_bcd_c, out_neg_c, out_nd_c}, {12'd0, 20'h0, 1'b0, 3'd1});
    drain(1'b0);

    // Back-pressure with a competing input word presented throughout.
    send(16'd4321); wait_valid();
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1; in_data = 16'hBEEF;
      @(posedge clk); #1;
      check("stall_in_ready", 32'(in_ready_a), 32'd0);
      check("stall_bcd", 32'(out_bcd_a), 32'h04321);
      check("stall_valid", 32'(out_valid_a), 32'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("release_valid", 32'(out_valid_a), 32'd0);
    check("release_ready", 32'(in_ready_a), 32'd1);

    // Asynchronous reset in the middle of a conversion.
    send(16'd1234);
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("abort_bcd", 32'(out_bcd_a), 32'd0);
    check("abort_flags", {28'd0, out_valid_a, out_neg_c, out_ovf_a, in_ready_a}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("abort_idle", 32'(in_ready_a), 32'd1);
    send(16'd42); wait_valid();
    check("after_abort_42", 32'(out_bcd_a), 32'h00042);
    drain(1'b0);

    // Mixed random and corner words with random back-pressure.
    for (int i = 0; i < 2000; i++) begin
      send((i % 25 == 0) ? corners[(i / 25) % 8] : 16'($urandom_range(0, 65535)));
      drain(1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
